// File: rtl/sw_led_pkg.sv
`default_nettype none
// ============================================================================
// sw_led_pkg : register offsets and debounce state encoding for sw_led_mmio
// Revision   : 1.0
// ============================================================================
package sw_led_pkg;

   localparam logic [1:0] LED_OFS  = 2'd0;
   localparam logic [1:0] SW_OFS   = 2'd1;
   localparam logic [1:0] EDGE_OFS = 2'd2;

   typedef enum logic [0:0] {
      DB_STABLE = 1'b0,
      DB_COUNT  = 1'b1
   } db_state_t;

endpackage
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// sw_debounce : 2-flop synchronizer plus counting debounce FSM for one switch
// Revision    : 1.0
// ============================================================================
module sw_debounce
   import sw_led_pkg::*;
#(
   parameter int DB_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic deb
);

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          deb_q, deb_d;
   logic [CW-1:0] cnt_q, cnt_d;
   db_state_t     state_q, state_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         cnt_q   <= '0;
         state_q <= DB_STABLE;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      deb_d   = deb_q;
      case (state_q)
         DB_STABLE: begin
            cnt_d = '0;
            if (sync2_q != deb_q) begin
               state_d = DB_COUNT;
               cnt_d   = CW'(1);
            end
         end
         DB_COUNT: begin
            // any sample that agrees with deb restarts the qualification window
            if (sync2_q == deb_q) begin
               state_d = DB_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = DB_STABLE;
               cnt_d   = '0;
               deb_d   = sync2_q;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = DB_STABLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign deb = deb_q;

endmodule
`default_nettype wire

// File: rtl/sw_led_mmio.sv
`default_nettype none
// ============================================================================
// sw_led_mmio : MMIO slave exposing LED (RW), debounced SW (RO), EDGE (W1C)
// Revision    : 1.0
// ============================================================================
module sw_led_mmio
   import sw_led_pkg::*;
#(
   parameter int          N_IO      = 10,
   parameter logic [15:0] BASE_ADDR = 16'hC000,
   parameter int          DB_CYCLES = 50000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [15:0]     addr,
   input  logic [15:0]     wdata,
   input  logic            we,
   input  logic            re,
   output logic [15:0]     rdata,
   output logic            rvalid,
   input  logic [N_IO-1:0] sw_in,
   output logic [N_IO-1:0] led_out,
   output logic            edge_irq
);

   logic [N_IO-1:0] deb;
   logic [N_IO-1:0] deb_prev_q;
   logic [N_IO-1:0] rise;
   logic [N_IO-1:0] led_q, led_d;
   logic [N_IO-1:0] edge_q, edge_d;
   logic [15:0]     rdata_q, rdata_d;
   logic [15:0]     rd_mux;
   logic            rvalid_q, rvalid_d;
   logic            irq_q, irq_d;
   logic            hit;
   logic [1:0]      ofs;
   logic            unused_wdata;

   generate
      for (genvar i = 0; i < N_IO; i++) begin : g_bit
         sw_debounce #(
            .DB_CYCLES (DB_CYCLES)
         ) u_deb (
            .clk (clk),
            .rst (rst),
            .raw (sw_in[i]),
            .deb (deb[i])
         );
      end
   endgenerate

   assign hit          = (addr[15:2] == BASE_ADDR[15:2]);
   assign ofs          = addr[1:0];
   assign rise         = deb & ~deb_prev_q;
   assign unused_wdata = ^wdata[15:N_IO];

   always_comb begin
      led_d = led_q;
      if (we && hit && (ofs == LED_OFS))
         led_d = wdata[N_IO-1:0];

      // clear first, then OR in new rises so a coincident set wins
      edge_d = edge_q;
      if (we && hit && (ofs == EDGE_OFS))
         edge_d = edge_q & ~wdata[N_IO-1:0];
      edge_d = edge_d | rise;

      rd_mux = '0;
      if (hit) begin
         case (ofs)
            LED_OFS:  rd_mux[N_IO-1:0] = led_q;
            SW_OFS:   rd_mux[N_IO-1:0] = deb;
            EDGE_OFS: rd_mux[N_IO-1:0] = edge_q;
            default:  rd_mux = '0;
         endcase
      end

      rdata_d  = re ? rd_mux : 16'h0000;
      rvalid_d = re;
      irq_d    = |edge_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         deb_prev_q <= '0;
         led_q      <= '0;
         edge_q     <= '0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         deb_prev_q <= deb;
         led_q      <= led_d;
         edge_q     <= edge_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         irq_q      <= irq_d;
      end
   end

   assign led_out  = led_q;
   assign rdata    = rdata_q;
   assign rvalid   = rvalid_q;
   assign edge_irq = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_sw_led_mmio.sv
`default_nettype none
// ============================================================================
// tb_sw_led_mmio : directed, table-driven bench for sw_led_mmio (DB_CYCLES=4)
// Revision       : 1.0
// ============================================================================
module tb_sw_led_mmio;

   localparam logic [15:0] A_LED  = 16'hC000;
   localparam logic [15:0] A_SW   = 16'hC001;
   localparam logic [15:0] A_EDGE = 16'hC002;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr, wdata, rdata;
   logic        we, re, rvalid, edge_irq;
   logic [9:0]  sw_in, led_out;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        we;
      logic        re;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic        exp_rvalid;
      logic [15:0] exp_rdata;
      logic [9:0]  exp_led;
   } vec_t;

   vec_t vecs[15];

   sw_led_mmio #(
      .N_IO      (10),
      .BASE_ADDR (16'hC000),
      .DB_CYCLES (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .wdata    (wdata),
      .we       (we),
      .re       (re),
      .rdata    (rdata),
      .rvalid   (rvalid),
      .sw_in    (sw_in),
      .led_out  (led_out),
      .edge_irq (edge_irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [15:0] a, input string name, input logic [15:0] exp);
      addr = a;
      re   = 1'b1;
      tick();
      re   = 1'b0;
      check({name, " rvalid"}, {31'd0, rvalid}, 32'd1);
      check(name, {16'd0, rdata}, {16'd0, exp});
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      tick();
      we    = 1'b0;
   endtask

   initial begin
      //         we    re    addr       wdata     rv    rdata     led
      vecs[0]  = '{1'b0, 1'b1, A_SW,     16'h0000, 1'b1, 16'h0000, 10'h000};
      vecs[1]  = '{1'b1, 1'b0, A_LED,    16'h0155, 1'b0, 16'h0000, 10'h155};
      vecs[2]  = '{1'b0, 1'b1, A_LED,    16'h0000, 1'b1, 16'h0155, 10'h155};
      vecs[3]  = '{1'b1, 1'b0, A_SW,     16'hFFFF, 1'b0, 16'h0000, 10'h155};
      vecs[4]  = '{1'b0, 1'b1, A_SW,     16'h0000, 1'b1, 16'h0000, 10'h155};
      vecs[5]  = '{1'b1, 1'b1, A_LED,    16'h02AA, 1'b1, 16'h0155, 10'h2AA};
      vecs[6]  = '{1'b0, 1'b1, A_LED,    16'h0000, 1'b1, 16'h02AA, 10'h2AA};
      vecs[7]  = '{1'b1, 1'b0, A_LED,    16'hFFFF, 1'b0, 16'h0000, 10'h3FF};
      vecs[8]  = '{1'b0, 1'b1, A_LED,    16'h0000, 1'b1, 16'h03FF, 10'h3FF};
      vecs[9]  = '{1'b0, 1'b1, 16'hC003, 16'h0000, 1'b1, 16'h0000, 10'h3FF};
      vecs[10] = '{1'b0, 1'b1, 16'hC004, 16'h0000, 1'b1, 16'h0000, 10'h3FF};
      vecs[11] = '{1'b1, 1'b0, 16'hD000, 16'h0000, 1'b0, 16'h0000, 10'h3FF};
      vecs[12] = '{1'b0, 1'b1, 16'hD000, 16'h0000, 1'b1, 16'h0000, 10'h3FF};
      vecs[13] = '{1'b0, 1'b0, A_LED,    16'h0000, 1'b0, 16'h0000, 10'h3FF};
      vecs[14] = '{1'b0, 1'b1, A_EDGE,   16'h0000, 1'b1, 16'h0000, 10'h3FF};

      rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; sw_in = '0;
      repeat (3) tick();
      rst = 1'b0;
      check("reset led_out",  {22'd0, led_out},  32'd0);
      check("reset edge_irq", {31'd0, edge_irq}, 32'd0);
      check("reset rvalid",   {31'd0, rvalid},   32'd0);
      check("reset rdata",    {16'd0, rdata},    32'd0);

      // register map / handshake table
      for (int i = 0; i < 15; i++) begin
         we    = vecs[i].we;
         re    = vecs[i].re;
         addr  = vecs[i].addr;
         wdata = vecs[i].wdata;
         tick();
         we = 1'b0;
         re = 1'b0;
         check($sformatf("vec%0d rvalid", i), {31'd0, rvalid}, {31'd0, vecs[i].exp_rvalid});
         if (vecs[i].exp_rvalid)
            check($sformatf("vec%0d rdata", i), {16'd0, rdata}, {16'd0, vecs[i].exp_rdata});
         check($sformatf("vec%0d led", i), {22'd0, led_out}, {22'd0, vecs[i].exp_led});
      end

      // debounce latency: deb rises at the 6th posedge after the pin change
      sw_in = 10'h001;
      repeat (5) tick();
      addr = A_SW;
      re   = 1'b1;
      tick();
      check("sw at +6 sample", {16'd0, rdata}, 32'h0000);
      tick();
      check("sw at +7 sample", {16'd0, rdata}, 32'h0001);
      re = 1'b0;
      repeat (3) tick();
      rd(A_EDGE, "edge after sw0 rise", 16'h0001);
      tick();
      check("edge_irq after sw0", {31'd0, edge_irq}, 32'd1);

      // three-sample glitch on sw_in[1] is rejected
      sw_in = 10'h003;
      repeat (3) tick();
      sw_in = 10'h001;
      repeat (10) tick();
      rd(A_SW,   "sw after glitch",   16'h0001);
      rd(A_EDGE, "edge after glitch", 16'h0001);

      // W1C behaviour
      sw_in = 10'h003;
      repeat (10) tick();
      rd(A_EDGE, "edge both set", 16'h0003);
      wr(A_EDGE, 16'h0001);
      rd(A_EDGE, "edge w1c bit0", 16'h0002);
      sw_in = 10'h001;
      repeat (10) tick();
      rd(A_EDGE, "edge no falling set", 16'h0002);
      wr(A_EDGE, 16'h0002);
      rd(A_EDGE, "edge w1c bit1", 16'h0000);
      check("edge_irq cleared", {31'd0, edge_irq}, 32'd0);

      // set collides with W1C: deb rises at +6, EDGE set commits at +7
      sw_in = 10'h003;
      repeat (6) tick();
      wr(A_EDGE, 16'h0002);
      rd(A_EDGE, "edge set beats w1c", 16'h0002);

      // reset in the middle of a count
      sw_in = 10'h007;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midreset led_out",  {22'd0, led_out},  32'd0);
      check("midreset edge_irq", {31'd0, edge_irq}, 32'd0);
      check("midreset rvalid",   {31'd0, rvalid},   32'd0);
      rd(A_EDGE, "edge after midreset", 16'h0000);
      repeat (4) tick();
      addr = A_SW;
      re   = 1'b1;
      tick();
      check("sw post-reset +6 sample", {16'd0, rdata}, 32'h0000);
      tick();
      check("sw post-reset +7 sample", {16'd0, rdata}, 32'h0007);
      re = 1'b0;
      repeat (3) tick();
      rd(A_EDGE, "edge post-reset", 16'h0007);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
